// File: rtl/node_input_arbiter_if.sv
// ============================================================================
// node_input_arbiter_if
// Port-side and controller-side signal bundle of the node input arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface node_input_arbiter_if #(
    parameter int DATA_W = 32
);
    logic [2:0]          in_valid;
    logic [3*DATA_W-1:0] in_data;
    logic [2:0]          in_ready;
    logic                downstream_ready;
    logic [DATA_W-1:0]   instruction_out;
    logic [1:0]          source_port;
    logic                controller_enable;

    modport master (
        output in_valid,
        output in_data,
        output downstream_ready,
        input  in_ready,
        input  instruction_out,
        input  source_port,
        input  controller_enable
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  downstream_ready,
        output in_ready,
        output instruction_out,
        output source_port,
        output controller_enable
    );
endinterface

`default_nettype wire

// File: rtl/node_input_arbiter.sv
// ============================================================================
// node_input_arbiter
// Three per-port instruction FIFOs feeding a one-per-cycle arbiter in front of
// the node controller. Define RING_PRIO_EN to give ring ports 1/2 priority.
// Revision: 1.0
// ============================================================================
`default_nettype none

module node_input_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2,
    parameter int DATA_W     = 32
) (
    input  wire logic         clk,
    input  wire logic         rst,
    node_input_arbiter_if.slave bus
);

    localparam logic [FIFO_AW:0] c_full = (FIFO_AW+1)'(FIFO_DEPTH);

    logic [2:0]        w_ready;
    logic [2:0]        w_nonempty;
    logic [DATA_W-1:0] w_head [3];
    logic              w_grant_valid;
    logic [1:0]        w_grant;
    logic [1:0]        w_rr_next;
    logic [DATA_W-1:0] w_head_sel;

    logic [1:0]        r_rr_ptr;
    logic [DATA_W-1:0] r_instruction;
    logic [1:0]        r_source_port;
    logic              r_enable;

    function automatic logic [1:0] f_mod3_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 3'd3) s = s - 3'd3;
        return s[1:0];
    endfunction

    for (genvar i = 0; i < 3; i++) begin : g_port
        logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
        logic [FIFO_AW-1:0] r_wr_ptr;
        logic [FIFO_AW-1:0] r_rd_ptr;
        logic [FIFO_AW:0]   r_count;
        logic               w_push;
        logic               w_pop;

        // A full FIFO refuses input even when it is popped this cycle.
        assign w_ready[i]    = !rst && (r_count != c_full);
        assign w_push        = bus.in_valid[i] && w_ready[i];
        assign w_pop         = w_grant_valid && (w_grant == 2'(i));
        assign w_nonempty[i] = (r_count != '0);
        assign w_head[i]     = r_mem[r_rd_ptr];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (w_push) r_mem[r_wr_ptr] <= bus.in_data[i*DATA_W +: DATA_W];
        end
    end

    assign bus.in_ready = w_ready;

`ifdef RING_PRIO_EN
    logic [1:0] w_ring_first;
    logic [1:0] w_ring_second;

    // rr_ptr only ever names a ring port here; its reset value 0 acts as 1.
    always_comb begin
        w_ring_first  = (r_rr_ptr == 2'd2) ? 2'd2 : 2'd1;
        w_ring_second = (r_rr_ptr == 2'd2) ? 2'd1 : 2'd2;
        w_grant_valid = 1'b0;
        w_grant       = 2'd0;
        w_rr_next     = r_rr_ptr;
        if (w_nonempty[w_ring_first]) begin
            w_grant_valid = bus.downstream_ready;
            w_grant       = w_ring_first;
            w_rr_next     = w_ring_second;
        end else if (w_nonempty[w_ring_second]) begin
            w_grant_valid = bus.downstream_ready;
            w_grant       = w_ring_second;
            w_rr_next     = w_ring_first;
        end else if (w_nonempty[0]) begin
            w_grant_valid = bus.downstream_ready;
            w_grant       = 2'd0;
        end
    end
`else
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant       = 2'd0;
        // Scan from the far end so the port closest to rr_ptr wins last.
        for (int k = 2; k >= 0; k--) begin
            if (w_nonempty[f_mod3_add(r_rr_ptr, 2'(k))]) begin
                w_grant_valid = bus.downstream_ready;
                w_grant       = f_mod3_add(r_rr_ptr, 2'(k));
            end
        end
        w_rr_next = f_mod3_add(w_grant, 2'd1);
    end
`endif

    always_comb begin
        w_head_sel = w_head[0];
        case (w_grant)
            2'd1:    w_head_sel = w_head[1];
            2'd2:    w_head_sel = w_head[2];
            default: w_head_sel = w_head[0];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr      <= 2'd0;
            r_instruction <= '0;
            r_source_port <= 2'd0;
            r_enable      <= 1'b0;
        end else begin
            r_enable <= w_grant_valid;
            if (w_grant_valid) begin
                r_instruction <= w_head_sel;
                r_source_port <= w_grant;
                r_rr_ptr      <= w_rr_next;
            end
        end
    end

    assign bus.instruction_out   = r_instruction;
    assign bus.source_port       = r_source_port;
    assign bus.controller_enable = r_enable;

endmodule

`default_nettype wire

// File: tb/tb_node_input_arbiter.sv
// ============================================================================
// tb_node_input_arbiter
// Directed self-checking bench for node_input_arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_node_input_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    node_input_arbiter_if #(.DATA_W(32)) bus ();

    node_input_arbiter #(
        .FIFO_DEPTH(4),
        .FIFO_AW   (2),
        .DATA_W    (32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int exp_port [6];
    int exp_word [6];

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.in_valid = 3'b000;
        bus.in_data = '0;
        bus.downstream_ready = 1'b0;

        // Reset state
        #2;
        chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
        chk("rst_enable", 32'(bus.controller_enable), 32'h0);
        chk("rst_instr", bus.instruction_out, 32'h0);
        chk("rst_src", 32'(bus.source_port), 32'h0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'h7);

        // Single word on port 2, one-cycle latency, one-cycle strobe
        bus.downstream_ready = 1'b1;
        bus.in_data[95:64] = 32'hA000_0001;
        bus.in_valid = 3'b100;
        tick();
        bus.in_valid = 3'b000;
        chk("single_pre_enable", 32'(bus.controller_enable), 32'h0);
        tick();
        chk("single_enable", 32'(bus.controller_enable), 32'h1);
        chk("single_instr", bus.instruction_out, 32'hA000_0001);
        chk("single_src", 32'(bus.source_port), 32'h2);
        tick();
        chk("single_enable_drop", 32'(bus.controller_enable), 32'h0);
        chk("single_instr_hold", bus.instruction_out, 32'hA000_0001);

        // Fairness: two words queued on every port
        bus.downstream_ready = 1'b0;
        for (int w = 0; w < 2; w++) begin
            bus.in_data[31:0]  = 32'hB000_0000 + 32'(w);
            bus.in_data[63:32] = 32'hB000_0100 + 32'(w);
            bus.in_data[95:64] = 32'hB000_0200 + 32'(w);
            bus.in_valid = 3'b111;
            tick();
        end
        bus.in_valid = 3'b000;
`ifdef RING_PRIO_EN
        exp_port = '{1, 2, 1, 2, 0, 0};
        exp_word = '{0, 0, 1, 1, 0, 1};
`else
        exp_port = '{0, 1, 2, 0, 1, 2};
        exp_word = '{0, 0, 0, 1, 1, 1};
`endif
        bus.downstream_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            tick();
            chk($sformatf("fair_enable_%0d", j), 32'(bus.controller_enable), 32'h1);
            chk($sformatf("fair_src_%0d", j), 32'(bus.source_port), 32'(exp_port[j]));
            chk($sformatf("fair_instr_%0d", j), bus.instruction_out,
                32'hB000_0000 + 32'(exp_port[j] * 256) + 32'(exp_word[j]));
        end
        tick();
        chk("fair_idle", 32'(bus.controller_enable), 32'h0);

        // Full FIFO on port 0: fifth word refused
        bus.downstream_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.in_data[31:0] = 32'hC000_0000 + 32'(k);
            bus.in_valid = 3'b001;
            chk($sformatf("full_ready_%0d", k), 32'(bus.in_ready[0]), (k < 4) ? 32'h1 : 32'h0);
            tick();
        end
        bus.in_valid = 3'b000;
        chk("full_ready_held", 32'(bus.in_ready), 32'h6);
        bus.downstream_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("full_enable_%0d", k), 32'(bus.controller_enable), 32'h1);
            chk($sformatf("full_src_%0d", k), 32'(bus.source_port), 32'h0);
            chk($sformatf("full_instr_%0d", k), bus.instruction_out, 32'hC000_0000 + 32'(k));
        end
        tick();
        chk("full_no_fifth", 32'(bus.controller_enable), 32'h0);
        chk("full_ready_back", 32'(bus.in_ready), 32'h7);

        // Stall: downstream_ready toggles with four words on port 1
        bus.downstream_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.in_data[63:32] = 32'hD000_0000 + 32'(k);
            bus.in_valid = 3'b010;
            tick();
        end
        bus.in_valid = 3'b000;
        for (int k = 0; k < 4; k++) begin
            bus.downstream_ready = 1'b1;
            tick();
            chk($sformatf("stall_enable_%0d", k), 32'(bus.controller_enable), 32'h1);
            chk($sformatf("stall_instr_%0d", k), bus.instruction_out, 32'hD000_0000 + 32'(k));
            chk($sformatf("stall_src_%0d", k), 32'(bus.source_port), 32'h1);
            bus.downstream_ready = 1'b0;
            tick();
            chk($sformatf("stall_gap_%0d", k), 32'(bus.controller_enable), 32'h0);
            chk($sformatf("stall_hold_%0d", k), bus.instruction_out, 32'hD000_0000 + 32'(k));
            chk($sformatf("stall_src_hold_%0d", k), 32'(bus.source_port), 32'h1);
        end
        bus.downstream_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk($sformatf("stall_no_repeat_%0d", k), 32'(bus.controller_enable), 32'h0);
        end

        // Reset mid-stream
        bus.downstream_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.in_data[63:32] = 32'hE000_0000 + 32'(k);
            bus.in_valid = 3'b010;
            tick();
        end
        bus.in_valid = 3'b000;
        bus.downstream_ready = 1'b1;
        tick();
        chk("mid_enable", 32'(bus.controller_enable), 32'h1);
        chk("mid_instr", bus.instruction_out, 32'hE000_0000);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_enable", 32'(bus.controller_enable), 32'h0);
        chk("mid_rst_instr", bus.instruction_out, 32'h0);
        chk("mid_rst_src", 32'(bus.source_port), 32'h0);
        chk("mid_rst_ready", 32'(bus.in_ready), 32'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("mid_after_ready", 32'(bus.in_ready), 32'h7);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("mid_after_idle_%0d", k), 32'(bus.controller_enable), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/node_input_arbiter.md
Name: node_input_arbiter

Overview:
- Input stage directly upstream of the node controller in each ring node.
- Buffers 32-bit instructions from three input ports (0 = local injection, 1 and 2 = ring links) in per-port FIFOs.
- Arbitrates one instruction per cycle and drives the controller's instruction_in, source_port and controller_enable inputs.

Parameters:
- FIFO_DEPTH, 4, entries per port FIFO; power of 2, minimum 2.
- FIFO_AW, 2, log2(FIFO_DEPTH); the pointer width.
- DATA_W, 32, instruction width; bits [31:29] hold the destination node and bits [28:26] the originating node (unused here).

Ports:
- clk  input  1  sole clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  3  bit i: port i presents a word.
- in_data  input  96  port i word at [32i+31:32i].
- in_ready  output  3  bit i: port i FIFO can accept a word.
- downstream_ready  input  1  the controller may take a new instruction this cycle.
- instruction_out  output  32  registered instruction to the controller.
- source_port  output  2  registered port index of instruction_out: 2'b00, 2'b01 or 2'b10, never 2'b11.
- controller_enable  output  1  registered one-cycle strobe; instruction_out/source_port are valid.

Behaviour:
- Reset (async, rst=1):
  - FIFO read/write pointers and counts go to 0.
  - rr_ptr goes to 0.
  - instruction_out=0, source_port=2'b00, controller_enable=0.
  - in_ready=3'b000 while rst is high.
  - Contents from before reset are discarded; there is no partial issue after reset.
- FIFO per port:
  - count is 0..FIFO_DEPTH, width FIFO_AW+1.
  - in_ready[i] = !rst && count_i != FIFO_DEPTH.
  - Push when in_valid[i] && in_ready[i]; the word is written at wr_ptr, which wraps modulo FIFO_DEPTH.
  - Pop when port i is granted; rd_ptr wraps modulo FIFO_DEPTH.
  - Push and pop in the same cycle leave count unchanged.
  - Full FIFO with a pop that cycle: in_ready stays 0, so there is no same-cycle refill.
  - There is no empty bypass.
- Arbiter (round-robin, rr_ptr in {0,1,2}):
  - Each edge with downstream_ready=1, scan ports in order rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3) and grant the first non-empty port g.
  - On a grant:
    - instruction_out <= head of FIFO g.
    - source_port <= g.
    - controller_enable <= 1.
    - rr_ptr <= (g+1) mod 3.
  - If no port is non-empty, or downstream_ready=0: controller_enable <= 0; instruction_out, source_port and rr_ptr hold.
- Timing and throughput:
  - Emptiness is evaluated on registered counts, so a word pushed at edge N is first eligible at edge N+1.
  - Minimum latency is 1 cycle from push to controller_enable high.
  - Throughput is 1 instruction per cycle aggregate.
  - Back-to-back grants of the same port are allowed when the other ports are empty.
- downstream_ready:
  - Dropping it stops issue on the next edge.
  - An instruction already strobed is not repeated.
- Invariants:
  - At most one grant per cycle.
  - No word is lost or duplicated.
  - Per-port order is preserved.

Optional Feature:
- Macro: RING_PRIO_EN.
- Defined:
  - Ports 1 and 2 (in-transit ring traffic) have strict priority over port 0.
  - Ports 1 and 2 round-robin between themselves using rr_ptr restricted to {1,2}.
  - Port 0 is granted only when ports 1 and 2 are both empty.
  - rr_ptr is unchanged by a port 0 grant.
- Undefined: plain 3-way round-robin as described in Behaviour.

Test Plan:
- Reset mid-stream: fill port 1 with 3 words, assert rst for 1 cycle mid-issue -> all outputs 0 immediately, in_ready=000 during rst, 111 after; no further controller_enable without new pushes.
- Single word: push 32'hA000_0001 on port 2 with downstream_ready=1 -> next edge instruction_out=32'hA000_0001, source_port=2'b10, controller_enable high for exactly 1 cycle.
- Full FIFO: push 5 words into port 0 with downstream_ready=0 -> in_ready[0] drops after the 4th word and the 5th is not accepted; raise downstream_ready -> the 4 words issue in order, source_port=00.
- Fairness: keep all 3 FIFOs non-empty -> grant sequence 0,1,2,0,1,2; controller_enable high every cycle.
- Stall: toggle downstream_ready every cycle with 4 words queued on port 1 -> exactly 4 strobes, in order, none repeated, outputs held during stalls.
- RING_PRIO_EN: ports 0, 1 and 2 each hold 2 words -> order 1,2,1,2,0,0; without the macro -> order 0,1,2,0,1,2.
